// File: rtl/period_if.sv
// Sample/threshold inputs and measurement outputs of the period meter.
// The master drives the samples and the slave returns the trigger and period.
interface period_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 24
);
    logic              sample_valid;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] mean;
    logic [DATA_W-1:0] amp;
    logic              trig;
    logic [CNT_W-1:0]  period;
    logic              period_valid;
    logic              no_signal;

    modport master (
        output sample_valid, data_in, mean, amp,
        input  trig, period, period_valid, no_signal
    );

    modport slave (
        input  sample_valid, data_in, mean, amp,
        output trig, period, period_valid, no_signal
    );
endinterface

// File: rtl/period_meter.sv
// Hysteresis trigger on rising mean-crossings, averaged period measurement
// in clk cycles, and loss-of-signal detection.
module period_meter #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned TIMEOUT    = 1000000,
    parameter int unsigned HYST_SHIFT = 2,
    parameter int unsigned AVG_LOG2   = 2
) (
    input logic     clk,
    input logic     rst_n,
    period_if.slave bus
);
    localparam int unsigned AccW  = CNT_W + AVG_LOG2;
    localparam int unsigned PcntW = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [PcntW-1:0] PcntLast   = PcntW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StHigh} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AccW-1:0]  acc_q, acc_d, acc_total;
    logic [PcntW-1:0] pcount_q, pcount_d;
    logic             first_q, first_d;
    logic             trig_q, trig_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             nosig_q, nosig_d;

    logic [DATA_W-1:0] hyst_raw, hyst, hi, lo;
    logic [DATA_W:0]   hi_sum, lo_diff;
    logic              at_lo, at_hi, crossing, timeout;

    // Thresholds clamp to the sample range instead of wrapping.
    always_comb begin
        hyst_raw = bus.amp >> HYST_SHIFT;
        hyst     = (hyst_raw == '0) ? DATA_W'(1) : hyst_raw;
        hi_sum   = {1'b0, bus.mean} + {1'b0, hyst};
        lo_diff  = {1'b0, bus.mean} - {1'b0, hyst};
        hi       = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
        lo       = lo_diff[DATA_W] ? '0 : lo_diff[DATA_W-1:0];
        at_lo    = bus.data_in <= lo;
        at_hi    = bus.data_in >= hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.sample_valid) begin
            unique case (state_q)
                StIdle:  if (at_lo) state_d = StArmed;
                StArmed: if (at_hi) state_d = StHigh;
                StHigh:  if (at_lo) state_d = StArmed;
                default: state_d = StIdle;
            endcase
        end
        if (timeout) state_d = StIdle;
    end

    // A crossing on the timeout cycle takes priority over the timeout.
    always_comb begin
        crossing = bus.sample_valid && (state_q == StArmed) && at_hi;
        timeout  = !crossing && (cnt_q == TimeoutVal);
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        pcount_d  = pcount_q;
        first_d   = first_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        nosig_d   = nosig_q;
        trig_d    = crossing;
        acc_total = acc_q + AccW'(cnt_q);
        if (crossing) begin
            cnt_d = CNT_W'(1);
            if (first_q) begin
                first_d = 1'b0;
            end else if (pcount_q == PcntLast) begin
                period_d = CNT_W'(acc_total >> AVG_LOG2);
                pv_d     = 1'b1;
                nosig_d  = 1'b0;
                acc_d    = '0;
                pcount_d = '0;
            end else begin
                acc_d    = acc_total;
                pcount_d = pcount_q + PcntW'(1);
            end
        end else if (timeout) begin
            nosig_d  = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            pcount_d = '0;
            first_d  = 1'b1;
        end else if (!first_q && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            pcount_q <= '0;
            first_q  <= 1'b1;
            trig_q   <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            nosig_q  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            pcount_q <= pcount_d;
            first_q  <= first_d;
            trig_q   <= trig_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            nosig_q  <= nosig_d;
        end
    end

    assign bus.trig         = trig_q;
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.no_signal    = nosig_q;
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Downstream of the amplitude finder in the oscilloscope datapath.
- Takes the 12-bit ADC sample stream plus the finder's mean and amp outputs, and derives a hysteresis trigger on rising mean-crossings.
- Measures the signal period in clk cycles, averages over 2^AVG_LOG2 periods, and flags loss of signal.
- Outputs feed the display/readout logic as the frequency measurement and the sweep trigger.

Parameters:
- DATA_W, 12, sample / mean / amp width.
- CNT_W, 24, period counter and period output width.
- TIMEOUT, 1000000, clk cycles without a crossing before no_signal is declared.
- HYST_SHIFT, 2, hysteresis band = amp >> HYST_SHIFT.
- AVG_LOG2, 2, number of periods averaged = 2^AVG_LOG2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sample_valid  input  1  data_in is a new sample this cycle.
- data_in  input  DATA_W  unsigned ADC sample.
- mean  input  DATA_W  signal mean from the amplitude finder.
- amp  input  DATA_W  half peak-to-peak from the amplitude finder.
- trig  output  1  one-cycle pulse on each rising crossing.
- period  output  CNT_W  averaged period in clk cycles.
- period_valid  output  1  one-cycle pulse when period updates.
- no_signal  output  1  high while no valid periodic signal is present.

Behaviour:
- Single clk domain. Reset is asynchronous and active-low. All outputs are registered.
- Reset values:
  - trig = 0, period = 0, period_valid = 0, no_signal = 1.
  - state = IDLE, cnt = 0, acc = 0, pcount = 0, first = 1.
- Thresholds (combinational, evaluated every cycle):
  - hyst = max(amp >> HYST_SHIFT, 1).
  - hi = min(mean + hyst, 2^DATA_W - 1), computed with a carry bit, no wrap.
  - lo = max(mean - hyst, 0), computed with borrow, no wrap.
- State machine, which advances only on sample_valid cycles:
  - IDLE: if data_in <= lo, go to ARMED.
  - ARMED: if data_in >= hi, a crossing occurs; go to HIGH.
  - HIGH: if data_in <= lo, go to ARMED.
  - If a sample satisfies both conditions in one cycle (degenerate thresholds), only one transition is taken per sample.
- Crossing cycle: trig = 1 on the next edge, for exactly one cycle.
- Counter:
  - When running, cnt increments every clk cycle, whether or not sample_valid is high, and saturates at 2^CNT_W - 1.
  - On a crossing cycle, measured = cnt and cnt <= 1. The period therefore equals the number of clk cycles between crossing cycles.
- First crossing after reset or timeout:
  - first <= 0 and the counter starts.
  - No measurement is taken.
- Later crossings:
  - acc <= acc + measured. acc is CNT_W + AVG_LOG2 bits wide.
  - pcount <= pcount + 1.
  - When pcount reaches 2^AVG_LOG2:
    - period <= acc_total >> AVG_LOG2, where acc_total includes the current measurement and the result is truncated.
    - period_valid pulses.
    - no_signal <= 0.
    - acc and pcount are cleared.
  - This happens on the same edge as trig.
- Timeout: if cnt == TIMEOUT on a cycle with no crossing:
  - no_signal <= 1, state <= IDLE.
  - cnt, acc and pcount are cleared; first <= 1.
  - period holds its last value.
  - A crossing on the same cycle wins, and the timeout is not taken.
- No signal stays asserted until the next period_valid.
- A change in mean or amp mid-measurement only affects the thresholds; accumulated data is kept.
- Reset asserted mid-measurement immediately returns every register to its reset value, including any in-flight pulse.

Test Plan:
- Reset: drive activity, pulse rst_n low asynchronously mid-period -> trig, period, period_valid = 0 and no_signal = 1 immediately, without waiting for a clk edge.
- Square wave between 1048 and 3048, period 100 cycles, sample_valid = 1, mean = 2048, amp = 1000 -> trig every 100 cycles; first period_valid on the 5th crossing with period = 100 and no_signal = 0.
- Periods 100, 102, 98, 104 after the first crossing -> period = 101 with a single period_valid pulse.
- Hysteresis: mean = 2048, amp = 1000 (hyst = 250), data oscillating 1900..2200 -> no trig, no period_valid, no_signal stays 1.
- Timeout: after a valid lock at period = 100, hold data_in at 2048 constant -> no_signal = 1 exactly TIMEOUT cycles after the last crossing, period stays 100; resume the signal -> new period_valid only after 5 crossings.
- Saturation: mean = 4000, amp = 800, data toggling 3200/4095 -> hi clamps to 4095 and a trig fires on 4095. mean = 50, amp = 400 -> lo clamps to 0 and the machine arms on data = 0.
